imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_boot_pkg.sv | 26 ++
 rtl/imem_boot_ctrl_if.sv | 30 +++
 rtl/imem_boot_ctrl_byte_word_pack.sv | 31 +++
 rtl/imem_boot_ctrl.sv | 117 +++++++++++
 tb/tb_imem_boot_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

  // Controller states:
  //   RUN  | core released, fetch address follows the PC
  //   HDR  | receiving the 2-byte little-endian word count
  //   DATA | receiving program words, 4 bytes each
  //   DONE | one-cycle completion strobe
  //   ERR  | header word count too large, waits for a new load request
  typedef enum logic [2:0] {
    RUN  = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // Word count from the two header bytes (first byte is the low byte).
  function automatic logic [15:0] hdr_count(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte stream, fetch and memory-write signals of the boot controller.
// slave is the controller side, master is the host/core side.
interface imem_boot_ctrl_if #(parameter int MEM_SIZE = 1024);
  localparam int AW = $clog2(MEM_SIZE);

  logic          Load_Req;
  logic [7:0]    Rx_Data;
  logic          Rx_Valid;
  logic          Rx_Ready;
  logic [31:0]   Program_Count;
  logic [31:0]   Fetch_Addr;
  logic          Mem_Wr_En;
  logic [AW-1:0] Mem_Wr_Addr;
  logic [31:0]   Mem_Wr_Data;
  logic          Core_Rst_N;
  logic          Load_Done;
  logic          Load_Err;

  modport master (
    output Load_Req, Rx_Data, Rx_Valid, Program_Count,
    input  Rx_Ready, Fetch_Addr, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data,
           Core_Rst_N, Load_Done, Load_Err
  );

  modport slave (
    input  Load_Req, Rx_Data, Rx_Valid, Program_Count,
    output Rx_Ready, Fetch_Addr, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data,
           Core_Rst_N, Load_Done, Load_Err
  );
endinterface

// File: rtl/imem_boot_ctrl_byte_word_pack.sv
// Shifts accepted bytes into a 32-bit little-endian word with a 2-bit byte count.
module byte_word_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  cnt,
  output logic [7:0]  last_byte,
  output logic [31:0] word_next
);
  logic [31:0] word_q;

  // New byte enters at the top, so after four shifts the first byte sits in bits 7:0.
  assign word_next = {byte_in, word_q[31:8]};
  assign last_byte = word_q[31:24];

  // Byte counter and shift register; clear takes priority over a byte in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      word_q <= 32'd0;
    end else if (clr) begin
      cnt    <= 2'd0;
      word_q <= 32'd0;
    end else if (en) begin
      cnt    <= cnt + 2'd1;
      word_q <= word_next;
    end
  end
endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: receives a length-prefixed byte stream, writes it into
// instruction memory and holds the core in reset until the load completes.
//   state | meaning
//   RUN   | core running, Fetch_Addr = Program_Count
//   HDR   | collecting word count N
//   DATA  | collecting and writing N words
//   DONE  | Load_Done strobe, then RUN
//   ERR   | N > MEM_SIZE, Load_Err held until Load_Req
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int MEM_SIZE      = 1024,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input logic              Clk_Core,
  input logic              Rst_Core_N,
  imem_boot_ctrl_if.slave  bus
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam state_t RST_STATE = BOOT_ON_RESET ? HDR : RUN;

  state_t        state, state_nx;
  logic          accept, hdr_last, word_last, wr_fire;
  logic [1:0]    cnt;
  logic [7:0]    last_byte;
  logic [31:0]   word_next;
  logic [15:0]   n_hdr, n_q, idx_q, idx_inc;
  logic          wr_en_q, load_err_q, core_rst_n_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;

  assign bus.Rx_Ready = (state == HDR) || (state == DATA);
  assign accept       = bus.Rx_Valid && bus.Rx_Ready;
  assign hdr_last     = (state == HDR)  && accept && (cnt == 2'(HDR_BYTES - 1));
  assign word_last    = (state == DATA) && accept && (cnt == 2'(WORD_BYTES - 1));
  // A load request in the same cycle as a completing word discards that word.
  assign wr_fire      = word_last && !bus.Load_Req;
  assign n_hdr        = hdr_count(bus.Rx_Data, last_byte);
  assign idx_inc      = idx_q + 16'd1;

  byte_word_pack u_pack (
    .clk       (Clk_Core),
    .rst_n     (Rst_Core_N),
    .clr       (bus.Load_Req || hdr_last),
    .en        (accept),
    .byte_in   (bus.Rx_Data),
    .cnt       (cnt),
    .last_byte (last_byte),
    .word_next (word_next)
  );

  // State register.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) state <= RST_STATE;
    else             state <= state_nx;
  end

  // Next-state decode; a load request overrides every state.
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:  state_nx = RUN;
      HDR: begin
        if (hdr_last) begin
          if (n_hdr == 16'd0)                 state_nx = DONE;
          else if (32'(n_hdr) > 32'(MEM_SIZE)) state_nx = ERR;
          else                                state_nx = DATA;
        end
      end
      DATA: if (word_last && (idx_inc == n_q)) state_nx = DONE;
      DONE: state_nx = RUN;
      ERR:  state_nx = ERR;
      default: state_nx = HDR;
    endcase
    if (bus.Load_Req) state_nx = HDR;
  end

  // Word counters, registered memory write, sticky error and core reset hold.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      n_q          <= 16'd0;
      idx_q        <= 16'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 32'd0;
      load_err_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      wr_en_q      <= wr_fire;
      core_rst_n_q <= (state_nx == RUN);
      if (bus.Load_Req) begin
        n_q        <= 16'd0;
        idx_q      <= 16'd0;
        load_err_q <= 1'b0;
      end else begin
        if (hdr_last) begin
          n_q   <= n_hdr;
          idx_q <= 16'd0;
        end
        if (wr_fire) begin
          wr_addr_q <= idx_q[AW-1:0];
          wr_data_q <= word_next;
          idx_q     <= idx_inc;
        end
        if (state_nx == ERR) load_err_q <= 1'b1;
      end
    end
  end

  assign bus.Fetch_Addr  = (state == RUN) ? bus.Program_Count : 32'd0;
  assign bus.Load_Done   = (state == DONE);
  assign bus.Load_Err    = load_err_q;
  assign bus.Core_Rst_N  = core_rst_n_q;
  assign bus.Mem_Wr_En   = wr_en_q;
  assign bus.Mem_Wr_Addr = wr_addr_q;
  assign bus.Mem_Wr_Data = wr_data_q;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl (boot-on-reset instance plus a run-on-reset instance).
module tb_imem_boot_ctrl;
  import imem_boot_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   w0;

  always #5 clk = ~clk;

  imem_boot_ctrl_if #(.MEM_SIZE(1024)) bi ();
  imem_boot_ctrl_if #(.MEM_SIZE(1024)) b0 ();

  imem_boot_ctrl #(.MEM_SIZE(1024), .BOOT_ON_RESET(1'b1)) dut (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .bus(bi));

  imem_boot_ctrl #(.MEM_SIZE(1024), .BOOT_ON_RESET(1'b0)) dut0 (
    .Clk_Core(clk), .Rst_Core_N(rst_n), .bus(b0));

  // Counts write strobes of the main instance, one per high cycle.
  always @(negedge clk) if (bi.Mem_Wr_En === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bi.Rx_Valid = 1'b1;
    bi.Rx_Data  = b;
    tick();
    bi.Rx_Valid = 1'b0;
    bi.Rx_Data  = 8'hEE;
  endtask

  task automatic pulse_load();
    bi.Load_Req = 1'b1;
    tick();
    bi.Load_Req = 1'b0;
  endtask

  initial begin
    bi.Load_Req = 1'b0; bi.Rx_Data = 8'h00; bi.Rx_Valid = 1'b0; bi.Program_Count = 32'h44;
    b0.Load_Req = 1'b0; b0.Rx_Data = 8'h00; b0.Rx_Valid = 1'b0; b0.Program_Count = 32'h1234;

    // Reset values
    tick(); tick();
    check("rst_core_n",  32'(bi.Core_Rst_N), 32'd0);
    check("rst_wr_en",   32'(bi.Mem_Wr_En), 32'd0);
    check("rst_wr_addr", 32'(bi.Mem_Wr_Addr), 32'd0);
    check("rst_wr_data", bi.Mem_Wr_Data, 32'd0);
    check("rst_done",    32'(bi.Load_Done), 32'd0);
    check("rst_err",     32'(bi.Load_Err), 32'd0);
    check("rst_state",   32'(dut.state), 32'(HDR));
    check("rst_ready",   32'(bi.Rx_Ready), 32'd1);
    check("rst_fetch",   bi.Fetch_Addr, 32'd0);
    check("rst0_state",  32'(dut0.state), 32'(RUN));
    check("rst0_core",   32'(b0.Core_Rst_N), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel0_core_pre", 32'(b0.Core_Rst_N), 32'd0);
    tick();
    check("rel0_core_post", 32'(b0.Core_Rst_N), 32'd1);
    check("rel0_fetch",     b0.Fetch_Addr, 32'h1234);
    check("rel_core_hdr",   32'(bi.Core_Rst_N), 32'd0);

    // Two-word program with gaps and ignored invalid bytes
    send_byte(8'h02); tick(); send_byte(8'h00);
    check("a_state_data", 32'(dut.state), 32'(DATA));
    send_byte(8'h13); tick(); tick(); send_byte(8'h00); send_byte(8'h00);
    check("a_no_wr_early", 32'(bi.Mem_Wr_En), 32'd0);
    send_byte(8'h00);
    check("a_w0_en",   32'(bi.Mem_Wr_En), 32'd1);
    check("a_w0_addr", 32'(bi.Mem_Wr_Addr), 32'd0);
    check("a_w0_data", bi.Mem_Wr_Data, 32'h00000013);
    send_byte(8'h93);
    check("a_wr_one_cycle", 32'(bi.Mem_Wr_En), 32'd0);
    send_byte(8'h00); send_byte(8'h10); tick(); send_byte(8'h00);
    check("a_w1_en",   32'(bi.Mem_Wr_En), 32'd1);
    check("a_w1_addr", 32'(bi.Mem_Wr_Addr), 32'd1);
    check("a_w1_data", bi.Mem_Wr_Data, 32'h00100093);
    check("a_done",    32'(bi.Load_Done), 32'd1);
    check("a_done_st", 32'(dut.state), 32'(DONE));
    check("a_done_core", 32'(bi.Core_Rst_N), 32'd0);
    check("a_done_ready", 32'(bi.Rx_Ready), 32'd0);
    tick();
    check("a_run_st",   32'(dut.state), 32'(RUN));
    check("a_run_core", 32'(bi.Core_Rst_N), 32'd1);
    check("a_run_done", 32'(bi.Load_Done), 32'd0);
    check("a_run_ready", 32'(bi.Rx_Ready), 32'd0);
    check("a_wr_count", 32'(wr_count), 32'd2);

    // Fetch address in RUN, then load request
    bi.Program_Count = 32'h10;
    #1;
    check("f_fetch_run", bi.Fetch_Addr, 32'h10);
    pulse_load();
    check("f_fetch_hdr", bi.Fetch_Addr, 32'd0);
    check("f_core_hdr",  32'(bi.Core_Rst_N), 32'd0);
    check("f_state",     32'(dut.state), 32'(HDR));

    // Zero-length header
    send_byte(8'h00); send_byte(8'h00);
    check("z_state", 32'(dut.state), 32'(DONE));
    check("z_done",  32'(bi.Load_Done), 32'd1);
    check("z_wr_en", 32'(bi.Mem_Wr_En), 32'd0);
    tick();
    check("z_run",   32'(dut.state), 32'(RUN));
    check("z_wr_count", 32'(wr_count), 32'd2);

    // Oversize header N=1025
    pulse_load();
    send_byte(8'h01); send_byte(8'h04);
    check("e_state", 32'(dut.state), 32'(ERR));
    check("e_err",   32'(bi.Load_Err), 32'd1);
    check("e_ready", 32'(bi.Rx_Ready), 32'd0);
    check("e_core",  32'(bi.Core_Rst_N), 32'd0);
    send_byte(8'h55); tick();
    check("e_stays", 32'(dut.state), 32'(ERR));
    check("e_sticky", 32'(bi.Load_Err), 32'd1);
    pulse_load();
    check("e_clr_state", 32'(dut.state), 32'(HDR));
    check("e_clr_err",   32'(bi.Load_Err), 32'd0);

    // N = MEM_SIZE fills every index
    w0 = wr_count;
    send_byte(8'h00); send_byte(8'h04);
    check("m_state_data", 32'(dut.state), 32'(DATA));
    for (int i = 0; i < 1024; i++) begin
      send_byte(8'(i)); send_byte(8'(i >> 8)); send_byte(8'h5A); send_byte(8'hC3);
    end
    check("m_last_addr", 32'(bi.Mem_Wr_Addr), 32'd1023);
    check("m_last_data", bi.Mem_Wr_Data, 32'hC35A03FF);
    check("m_done",      32'(bi.Load_Done), 32'd1);
    tick();
    check("m_wr_count",  32'(wr_count - w0), 32'd1024);

    // Load request coinciding with the 4th byte of word 0
    pulse_load();
    w0 = wr_count;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    bi.Load_Req = 1'b1;
    send_byte(8'hA4);
    bi.Load_Req = 1'b0;
    check("c_no_wr",  32'(bi.Mem_Wr_En), 32'd0);
    check("c_state",  32'(dut.state), 32'(HDR));
    check("c_cnt",    32'(dut.u_pack.cnt), 32'd0);
    check("c_idx",    32'(dut.idx_q), 32'd0);
    tick();
    check("c_wr_count", 32'(wr_count - w0), 32'd0);

    // Reset pulse after two of four words
    send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    check("r_w1_data", bi.Mem_Wr_Data, 32'h88776655);
    send_byte(8'h99);
    check("r_wr_count2", 32'(wr_count - w0), 32'd2);
    bi.Rx_Valid = 1'b1; bi.Rx_Data = 8'hAA;
    rst_n = 1'b0;
    #1;
    check("r_core",  32'(bi.Core_Rst_N), 32'd0);
    check("r_wr_en", 32'(bi.Mem_Wr_En), 32'd0);
    check("r_addr",  32'(bi.Mem_Wr_Addr), 32'd0);
    check("r_data",  bi.Mem_Wr_Data, 32'd0);
    check("r_done",  32'(bi.Load_Done), 32'd0);
    check("r_err",   32'(bi.Load_Err), 32'd0);
    check("r_state", 32'(dut.state), 32'(HDR));
    check("r_cnt",   32'(dut.u_pack.cnt), 32'd0);
    tick(); tick();
    bi.Rx_Valid = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    check("r_wr_count_after", 32'(wr_count - w0), 32'd2);
    check("r_idx_after",      32'(dut.idx_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
